// File: rtl/cpu_pkg.sv
// Shared definitions for the memory stage: funct3 access-size codes and the
// encoding of the memory access FSM.
package cpu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mau_state_e;

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load data alignment: picks the addressed byte/half out of the memory word
// and sign- or zero-extends it according to funct3. Purely combinational.
module load_align
  import cpu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  // Shift the addressed lane down to bit 0, then extend by access type
  always_comb begin
    shifted = rdata_i >> {addr_lo_i, 3'b000};
    case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   data_o = {24'h0, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   data_o = {16'h0, shifted[15:0]};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data memory access unit: converts the EX/MEM load/store request
// into a req/ack transaction, stalls the pipeline while it is outstanding and
// presents extended load data for MEM/WB.
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] RDData_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  output logic        stall_o,
  output logic [31:0] MemData_o,
  output logic        valid_o,
  output logic        misalign_o,
  output logic        err_o
);

  mau_state_e        state_q, state_d;
  logic [31:0]       addr_q;
  logic              we_q;
  logic [3:0]        be_q, be_new;
  logic [31:0]       wdata_q, wdata_new;
  logic [2:0]        f3_q;
  logic [1:0]        addr_lo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       memdata_q;
  logic              err_q, misalign_q;

  logic        access, is_byte, is_half, aligned, accept, timeout, ack_w;
  logic [2:0]  f3;
  logic [31:0] load_data;

  // Only funct3 is meaningful in the instruction word here
  logic unused_instr;
  assign unused_instr = ^{instr_i[31:15], instr_i[11:0]};

  assign f3      = instr_i[14:12];
  assign access  = MemRead_i | MemWrite_i;
  assign accept  = (state_q == IDLE) && access && aligned;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign ack_w   = (state_q == WAIT) && dmem_ack_i;

  // Access size decode, alignment check and store lane generation
  always_comb begin
    is_byte   = 1'b0;
    is_half   = 1'b0;
    be_new    = 4'hF;
    wdata_new = 32'h0;
    if (MemWrite_i) begin
      is_byte = (f3 == F3_B);
      is_half = (f3 == F3_H);
    end else begin
      is_byte = (f3 == F3_B) || (f3 == F3_BU);
      is_half = (f3 == F3_H) || (f3 == F3_HU);
    end
    aligned = is_byte || (is_half && !ALUResult_i[0]) ||
              (!is_byte && !is_half && (ALUResult_i[1:0] == 2'b00));
    if (MemWrite_i) begin
      if (is_byte) begin
        be_new    = 4'b0001 << ALUResult_i[1:0];
        wdata_new = {4{RDData_i[7:0]}};
      end else if (is_half) begin
        be_new    = 4'b0011 << {ALUResult_i[1], 1'b0};
        wdata_new = {2{RDData_i[15:0]}};
      end else begin
        be_new    = 4'hF;
        wdata_new = RDData_i;
      end
    end
  end

  load_align u_load_align (
    .rdata_i   (dmem_rdata_i),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (f3_q),
    .data_o    (load_data)
  );

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and pipeline stall
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        stall_o = accept;
        if (accept) state_d = WAIT;
      end
      WAIT: begin
        stall_o = 1'b1;
        if (dmem_ack_i || timeout) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst_i) stall_o = 1'b0;
  end

  // Request fields, timeout counter, load data capture and status pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q     <= 32'h0;
      we_q       <= 1'b0;
      be_q       <= 4'h0;
      wdata_q    <= 32'h0;
      f3_q       <= 3'b000;
      addr_lo_q  <= 2'b00;
      cnt_q      <= '0;
      memdata_q  <= 32'h0;
      err_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= (state_q == IDLE) && access && !aligned;
      err_q      <= (state_q == WAIT) && !dmem_ack_i && timeout;
      if (accept) begin
        addr_q    <= {ALUResult_i[31:2], 2'b00};
        we_q      <= MemWrite_i;
        be_q      <= be_new;
        wdata_q   <= wdata_new;
        f3_q      <= f3;
        addr_lo_q <= ALUResult_i[1:0];
        cnt_q     <= '0;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (ack_w)                              memdata_q <= we_q ? 32'h0 : load_data;
      else if (state_q == WAIT && timeout)    memdata_q <= 32'h0;
    end
  end

  assign dmem_req_o   = (state_q == WAIT);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign dmem_be_o    = be_q;
  assign MemData_o    = memdata_q;
  assign valid_o      = (state_q == DONE);
  assign err_o        = err_q;
  assign misalign_o   = misalign_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Turns the registered MemRead/MemWrite, ALU address, store data and funct3 into a request/acknowledge transaction with data memory.
- Produces byte enables, store-data replication and load sign/zero extension.
- Stalls the pipeline until the transaction completes, then presents load data for MEM/WB.

Parameters:
- TIMEOUT_CYCLES, 16, number of WAIT cycles without dmem_ack_i before the access is aborted with err_o.
- CNT_W, 5, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- MemRead_i  in  1  load request from EX/MEM.
- MemWrite_i  in  1  store request from EX/MEM.
- ALUResult_i  in  32  byte address.
- RDData_i  in  32  store data (rs2).
- instr_i  in  32  instruction; funct3 = instr_i[14:12].
- dmem_rdata_i  in  32  memory read word.
- dmem_ack_i  in  1  memory completion, one-cycle pulse.
- dmem_req_o  out  1  request valid.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  32  word address ({addr[31:2],2'b00}).
- dmem_wdata_o  out  32  lane-replicated store data.
- dmem_be_o  out  4  byte enables.
- stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- MemData_o  out  32  extended load data.
- valid_o  out  1  one-cycle completion pulse.
- misalign_o  out  1  one-cycle misaligned-access pulse.
- err_o  out  1  one-cycle timeout pulse.

Behaviour:
- Reset: state = IDLE. All outputs are 0, including MemData_o and the timeout counter. A reset during WAIT drops dmem_req_o at the same edge, and any late ack is ignored.
- FSM states are IDLE, WAIT and DONE.
- IDLE, access requested:
  - An access is requested when MemRead_i | MemWrite_i.
  - If MemWrite_i is set, the access is a write, even if MemRead_i is also set.
  - Alignment rules: halfword requires addr[0] = 0; word requires addr[1:0] = 0.
  - Aligned: stall_o = 1 combinationally in this cycle. Register addr, we, be, wdata, funct3 and addr[1:0], then go to WAIT.
  - Misaligned: no request and no stall. misalign_o pulses on the next cycle. Stay in IDLE.
- IDLE, no access: stall_o = 0.
- WAIT:
  - dmem_req_o = 1, and the request fields stay stable until ack.
  - stall_o = 1.
  - The counter increments each cycle.
  - On dmem_ack_i: capture the extracted load data (writes capture 0) and go to DONE. dmem_req_o deasserts on the next edge.
  - When the counter reaches TIMEOUT_CYCLES-1 without ack: go to DONE with err_o = 1 and MemData_o = 0.
  - An ack and the timeout in the same cycle resolve as an ack.
- DONE:
  - stall_o = 0, valid_o = 1 (err_o = 1 if the access timed out).
  - MemData_o is valid for MEM/WB.
  - The EX/MEM register advances at the end of this cycle.
  - Next state is IDLE unconditionally, so the same instruction is never re-issued.
- MemData_o holds its value until the next completion.
- Latency: with ack arriving k cycles after WAIT entry (k ≥ 1), stall lasts k+1 cycles, and valid_o rises k+1 cycles after the IDLE request cycle.
- funct3 handling:
  - 000 = LB/SB, 001 = LH/SH, 010 = LW/SW, 100 = LBU, 101 = LHU.
  - Any other code is treated as word.
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011 << {addr[1],1'b0}; wdata = {2{rs2[15:0]}}.
  - SW: be = 4'hF; wdata = rs2.
- Loads: be = 4'hF. Select the byte or half using the registered addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- A dmem_ack_i seen in IDLE or DONE is ignored.

Decomposition:
- Shared package (cpu_pkg):
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encoding (IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2).
- Sub-module load_align: purely combinational. Inputs are rdata, addr[1:0] and funct3; output is the 32-bit extended value. It is reused by the future writeback bypass path.
- Store lane generation stays inline.

Test Plan:
- SW: addr 0x0000_0104, rs2 0xDEADBEEF, ack after 2 cycles → req with addr 0x104, be 4'hF, wdata 0xDEADBEEF, we = 1; stall 3 cycles; valid_o pulse; MemData_o = 0.
- LB/LBU: addr 0x0000_0203, rdata 0x80FF_1234, ack after 1 cycle → LB gives MemData_o 0xFFFF_FF80; LBU gives 0x0000_0080; stall 2 cycles.
- SH: addr 0x0000_0012, rs2 0x1234_ABCD → be 4'b1100, wdata 0xABCD_ABCD, addr 0x10.
- Misaligned LW at 0x0000_0006 → no dmem_req_o, stall_o = 0, misalign_o = 1 for one cycle.
- No ack for 16 WAIT cycles → err_o and valid_o pulse together, MemData_o = 0, FSM returns to IDLE, req drops.
- rst_i asserted in the second WAIT cycle with ack arriving one cycle later → req = 0 and stall = 0 after the edge; the ack produces no valid_o.
